// File: rtl/dht_pkg.sv
// Shared types and constants for the DHT poll scheduler: FSM states,
// 40-bit frame byte offsets and default timing.
package dht_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CHECK,
    S_FAIL,
    S_GAP
  } state_t;

  // Frame layout, MSB first: hum_int, hum_dec, temp_int, temp_dec, checksum
  localparam int HUM_INT_LSB  = 32;
  localparam int HUM_DEC_LSB  = 24;
  localparam int TEMP_INT_LSB = 16;
  localparam int TEMP_DEC_LSB = 8;
  localparam int CSUM_LSB     = 0;

  localparam int TIMEOUT_US_DEF = 25000;
  localparam int GAP_US_DEF     = 1000;
  localparam int MAX_RETRY_DEF  = 2;

  function automatic logic [7:0] frame_byte(input logic [39:0] f, input int lsb);
    return f[lsb +: 8];
  endfunction

endpackage

// File: rtl/dht_csum.sv
// Combinational DHT frame checksum: low byte must equal the 8-bit wrapped
// sum of the four data bytes.
module dht_csum
  import dht_pkg::*;
(
  input  logic [39:0] eng_data,
  output logic        pass
);

  logic [7:0] sum;

  assign sum  = frame_byte(eng_data, HUM_INT_LSB)  + frame_byte(eng_data, HUM_DEC_LSB)
              + frame_byte(eng_data, TEMP_INT_LSB) + frame_byte(eng_data, TEMP_DEC_LSB);
  assign pass = (sum == frame_byte(eng_data, CSUM_LSB));

endmodule

// File: rtl/dht_poll_sched.sv
// Sequences one shared DHT read engine across NCH sensor wires on each 5 s strobe.
// Build option: define DHT_RETRY_EN to retry failed channels up to MAX_RETRY times.
module dht_poll_sched
  import dht_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int TIMEOUT_US = TIMEOUT_US_DEF,
  parameter int GAP_US     = GAP_US_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic        clk1M,
  input  logic        rst,
  input  logic        flag_five_sec,
  output logic        eng_start,
  output logic [1:0]  eng_sel,
  input  logic        eng_done,
  input  logic [39:0] eng_data,
  output logic        upd,
  output logic [1:0]  upd_ch,
  output logic [7:0]  hum,
  output logic [7:0]  temp,
  output logic        err,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_US + 1);
  localparam int GW = $clog2(GAP_US + 1);

  state_t          state;
  logic [2:0]      sync;
  logic            flag_edge;
  logic            pend;
  logic [TW-1:0]   tmr;
  logic [GW-1:0]   gcnt;
  logic            csum_ok;
  logic            tmo;

`ifdef DHT_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0]   tries;
  logic            retry;
`else
  logic            unused_retry;
  assign unused_retry = (MAX_RETRY < 0);
`endif

  dht_csum u_csum (
    .eng_data (eng_data),
    .pass     (csum_ok)
  );

  assign flag_edge = (sync[2:1] == 2'b01);
  // tmr numbers cycles from eng_start (START is cycle 1), so the last WAIT
  // cycle is cycle TIMEOUT_US and FAIL lands exactly TIMEOUT_US after eng_start.
  assign tmo       = (tmr == TW'(TIMEOUT_US));

  always_ff @(posedge clk1M) begin
    if (rst) begin
      state     <= S_IDLE;
      sync      <= '0;
      pend      <= 1'b0;
      tmr       <= '0;
      gcnt      <= '0;
      eng_start <= 1'b0;
      eng_sel   <= '0;
      upd       <= 1'b0;
      err       <= 1'b0;
      upd_ch    <= '0;
      hum       <= '0;
      temp      <= '0;
      busy      <= 1'b0;
`ifdef DHT_RETRY_EN
      tries     <= '0;
      retry     <= 1'b0;
`endif
    end else begin
      sync      <= {sync[1:0], flag_five_sec};
      eng_start <= 1'b0;
      upd       <= 1'b0;
      err       <= 1'b0;
      if (flag_edge && state != S_IDLE)
        pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (flag_edge) begin
            state     <= S_START;
            eng_start <= 1'b1;
            eng_sel   <= '0;
            busy      <= 1'b1;
`ifdef DHT_RETRY_EN
            tries     <= '0;
`endif
          end
        end

        S_START: begin
          state <= S_WAIT;
          tmr   <= TW'(2);
        end

        S_WAIT: begin
          tmr <= tmr + TW'(1);
          if (eng_done)
            state <= S_CHECK;
          else if (tmo)
            state <= S_FAIL;

          if (eng_done && csum_ok) begin
            upd    <= 1'b1;
            upd_ch <= eng_sel;
            hum    <= frame_byte(eng_data, HUM_INT_LSB);
            temp   <= frame_byte(eng_data, TEMP_INT_LSB);
          end else if (eng_done || tmo) begin
`ifdef DHT_RETRY_EN
            if (tries == RW'(MAX_RETRY)) begin
              err    <= 1'b1;
              upd_ch <= eng_sel;
            end else begin
              retry  <= 1'b1;
            end
`else
            err    <= 1'b1;
            upd_ch <= eng_sel;
`endif
          end
        end

        S_CHECK, S_FAIL: begin
          state <= S_GAP;
          gcnt  <= '0;
        end

        S_GAP: begin
          if (gcnt == GW'(GAP_US - 1)) begin
`ifdef DHT_RETRY_EN
            if (retry) begin
              state     <= S_START;
              eng_start <= 1'b1;
              retry     <= 1'b0;
              tries     <= tries + RW'(1);
            end else
`endif
            if (eng_sel != 2'(NCH - 1)) begin
              state     <= S_START;
              eng_start <= 1'b1;
              eng_sel   <= eng_sel + 2'd1;
`ifdef DHT_RETRY_EN
              tries     <= '0;
`endif
            end else if (pend || flag_edge) begin
              // Back-to-back round: skip IDLE and consume the pending strobe
              state     <= S_START;
              eng_start <= 1'b1;
              eng_sel   <= '0;
              pend      <= 1'b0;
`ifdef DHT_RETRY_EN
              tries     <= '0;
`endif
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
